// File: rtl/instability_sweep_ctrl_pkg.sv
// Shared types and default constants for the instability sweep controller.
package instability_sweep_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StWaitQ,
        StLocked,
        StFail
    } state_e;

    typedef enum logic {
        PhCoarse,
        PhFine
    } phase_e;

    localparam int unsigned DefWidth        = 10;
    localparam int unsigned DefDelta        = 300;
    localparam int unsigned DefCoarseStep   = 50;
    localparam int unsigned DefFineStep     = 5;
    localparam int unsigned DefSettleCycles = 16;
    localparam int unsigned DefIrefMin      = 0;

endpackage

// File: rtl/instability_sweep_ctrl_settle_timer.sv
// Loadable down-counter: after a load, done_o rises on the SETTLE_CYCLES-th enabled clock.
module instability_sweep_ctrl_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CntW-1:0] LoadVal = CntW'(SETTLE_CYCLES - 1);
    localparam logic [CntW-1:0] One     = CntW'(1);

    logic [CntW-1:0] count_q, count_d;

    // Reload on entry, then count down to zero while enabled.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LoadVal;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - One;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = en_i && (count_q == '0);

endmodule

// File: rtl/instability_sweep_ctrl.sv
// Two-phase (coarse, then fine) i_ref sweep that stops at the onset of Q instability.
module instability_sweep_ctrl
    import instability_sweep_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH         = DefWidth,
    parameter int unsigned DELTA         = DefDelta,
    parameter int unsigned COARSE_STEP   = DefCoarseStep,
    parameter int unsigned FINE_STEP     = DefFineStep,
    parameter int unsigned SETTLE_CYCLES = DefSettleCycles,
    parameter int unsigned IREF_MIN      = DefIrefMin
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             q_valid,
    input  logic [WIDTH-1:0] q_measured,
    output logic [WIDTH-1:0] i_ref_setup,
    output logic             busy,
    output logic             locked,
    output logic             fail,
    output logic [WIDTH-1:0] q_peak,
    output logic [WIDTH-1:0] i_ref_at_peak
);

    localparam logic [WIDTH-1:0]        CoarseStepW = WIDTH'(COARSE_STEP);
    localparam logic [WIDTH-1:0]        FineStepW   = WIDTH'(FINE_STEP);
    localparam logic [WIDTH-1:0]        IrefMinW    = WIDTH'(IREF_MIN);
    localparam logic signed [WIDTH:0]   DeltaS      = (WIDTH + 1)'(DELTA);

    state_e           state_q, state_d;
    phase_e           phase_q, phase_d;
    logic [WIDTH-1:0] i_ref_q, i_ref_d;
    logic [WIDTH-1:0] q_prev_q, q_prev_d;
    logic             has_prev_q, has_prev_d;
    logic             busy_q, busy_d;
    logic             locked_q, locked_d;
    logic             fail_q, fail_d;
    logic [WIDTH-1:0] q_peak_q, q_peak_d;
    logic [WIDTH-1:0] i_ref_at_peak_q, i_ref_at_peak_d;

    logic signed [WIDTH:0] diff;
    logic [WIDTH-1:0]      step;
    logic                  unstable, at_floor, start_ok, sample;
    logic                  timer_load, timer_en, timer_done;

    instability_sweep_ctrl_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (timer_load),
        .en_i   (timer_en),
        .done_o (timer_done)
    );

    // Sample evaluation and handshake qualification shared by both comb processes.
    always_comb begin
        step     = (phase_q == PhCoarse) ? CoarseStepW : FineStepW;
        // Signed WIDTH+1 difference so a falling Q can never look like a large rise.
        diff     = $signed({1'b0, q_measured}) - $signed({1'b0, q_prev_q});
        unstable = has_prev_q && (diff > DeltaS);
        at_floor = (i_ref_q - IrefMinW) < step;
        start_ok = start && !abort;
        sample   = (state_q == StWaitQ) && q_valid && !abort;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StLocked, StFail: begin
                if (start_ok) state_d = StSettle;
            end
            StSettle: begin
                if (timer_done) state_d = StWaitQ;
            end
            StWaitQ: begin
                if (sample) begin
                    if (unstable) begin
                        state_d = (phase_q == PhCoarse) ? StSettle : StLocked;
                    end else begin
                        state_d = at_floor ? StFail : StSettle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort) state_d = StIdle;
    end

    assign timer_load = (state_d == StSettle) && (state_q != StSettle);
    assign timer_en   = (state_q == StSettle);

    // Datapath and flag next-state values.
    always_comb begin
        phase_d         = phase_q;
        i_ref_d         = i_ref_q;
        q_prev_d        = q_prev_q;
        has_prev_d      = has_prev_q;
        locked_d        = locked_q;
        fail_d          = fail_q;
        q_peak_d        = q_peak_q;
        i_ref_at_peak_d = i_ref_at_peak_q;
        busy_d          = (state_d == StSettle) || (state_d == StWaitQ);

        if (start_ok && (state_q inside {StIdle, StLocked, StFail})) begin
            i_ref_d         = '1;
            phase_d         = PhCoarse;
            has_prev_d      = 1'b0;
            locked_d        = 1'b0;
            fail_d          = 1'b0;
            q_peak_d        = '0;
            i_ref_at_peak_d = '1;
        end else if (sample) begin
            if (!unstable) begin
                if (q_measured > q_peak_q) begin
                    q_peak_d        = q_measured;
                    i_ref_at_peak_d = i_ref_q;
                end
                q_prev_d   = q_measured;
                has_prev_d = 1'b1;
                if (at_floor) begin
                    fail_d = 1'b1;
                end else begin
                    i_ref_d = i_ref_q - step;
                end
            end else if (phase_q == PhCoarse) begin
                // Back off to the last stable coarse point and refine from there.
                i_ref_d    = i_ref_q + CoarseStepW;
                phase_d    = PhFine;
                has_prev_d = 1'b0;
            end else begin
                i_ref_d  = i_ref_q + FineStepW;
                locked_d = 1'b1;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q         <= PhCoarse;
            i_ref_q         <= '1;
            q_prev_q        <= '0;
            has_prev_q      <= 1'b0;
            busy_q          <= 1'b0;
            locked_q        <= 1'b0;
            fail_q          <= 1'b0;
            q_peak_q        <= '0;
            i_ref_at_peak_q <= '1;
        end else begin
            phase_q         <= phase_d;
            i_ref_q         <= i_ref_d;
            q_prev_q        <= q_prev_d;
            has_prev_q      <= has_prev_d;
            busy_q          <= busy_d;
            locked_q        <= locked_d;
            fail_q          <= fail_d;
            q_peak_q        <= q_peak_d;
            i_ref_at_peak_q <= i_ref_at_peak_d;
        end
    end

    assign i_ref_setup   = i_ref_q;
    assign busy          = busy_q;
    assign locked        = locked_q;
    assign fail          = fail_q;
    assign q_peak        = q_peak_q;
    assign i_ref_at_peak = i_ref_at_peak_q;

endmodule

// File: tb/tb_instability_sweep_ctrl.sv
// Directed bench for instability_sweep_ctrl with hand-computed expectations.
module tb_instability_sweep_ctrl;

    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         q_valid = 1'b0;
    logic [W-1:0] q_measured = '0;
    logic [W-1:0] i_ref_setup, q_peak, i_ref_at_peak;
    logic         busy, locked, fail;

    int unsigned total = 0;
    int unsigned bad = 0;

    instability_sweep_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .q_valid       (q_valid),
        .q_measured    (q_measured),
        .i_ref_setup   (i_ref_setup),
        .busy          (busy),
        .locked        (locked),
        .fail          (fail),
        .q_peak        (q_peak),
        .i_ref_at_peak (i_ref_at_peak)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start pulse; returns one step after the edge that enters the first settle.
    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // From the cycle after an i_ref change: wait out the settle time, deliver one sample.
    task automatic feed(input logic [W-1:0] q);
        tick(16);
        q_valid    = 1'b1;
        q_measured = q;
        tick(1);
        q_valid    = 1'b0;
    endtask

    function automatic logic [W-1:0] plant_q(input int iref);
        return (iref > 730) ? W'(100) : W'(500);
    endfunction

    initial begin
        // 1. Reset values.
        tick(2);
        rst = 1'b0;
        tick(3);
        check("rst_iref", i_ref_setup, 1023);
        check("rst_busy", busy, 0);
        check("rst_locked", locked, 0);
        check("rst_fail", fail, 0);
        check("rst_qpeak", q_peak, 0);
        check("rst_atpeak", i_ref_at_peak, 1023);

        // 2. Monotonic Q never jumps: coarse sweep down to the floor.
        do_start();
        check("t2_busy", busy, 1);
        for (int k = 0; k <= 20; k++) begin
            check("t2_iref", i_ref_setup, 1023 - 50 * k);
            feed(W'(50 * k));
        end
        check("t2_fail", fail, 1);
        check("t2_busy_end", busy, 0);
        check("t2_locked", locked, 0);
        check("t2_iref_end", i_ref_setup, 23);
        check("t2_qpeak", q_peak, 1000);
        check("t2_atpeak", i_ref_at_peak, 23);

        // 3. Step plant: coarse detect at 723, back-off to 773, fine detect at 728.
        do_start();
        check("t3_fail_clr", fail, 0);
        check("t3_qpeak_clr", q_peak, 0);
        for (int k = 0; k <= 6; k++) begin
            check("t3_coarse", i_ref_setup, 1023 - 50 * k);
            feed(plant_q(1023 - 50 * k));
        end
        check("t3_backoff", i_ref_setup, 773);
        for (int k = 0; k <= 9; k++) begin
            check("t3_fine", i_ref_setup, 773 - 5 * k);
            feed(plant_q(773 - 5 * k));
        end
        check("t3_locked", locked, 1);
        check("t3_busy", busy, 0);
        check("t3_iref", i_ref_setup, 733);
        check("t3_qpeak", q_peak, 100);
        check("t3_atpeak", i_ref_at_peak, 1023);

        // 4. Settle timing: pulses at cycles 5 and 15 ignored, cycle 17 accepted.
        do_start();
        check("t4_locked_clr", locked, 0);
        tick(4);
        q_valid = 1'b1; q_measured = 900;
        tick(1);
        q_valid = 1'b0;
        tick(9);
        q_valid = 1'b1; q_measured = 900;
        tick(1);
        q_valid = 1'b0;
        check("t4_ignored", i_ref_setup, 1023);
        tick(1);
        check("t4_hold17", i_ref_setup, 1023);
        q_valid = 1'b1; q_measured = 10;
        tick(1);
        q_valid = 1'b0;
        check("t4_accept", i_ref_setup, 973);
        check("t4_qpeak", q_peak, 10);

        // 5. Abort during the third settle, then start+abort in idle.
        feed(10);
        check("t5_third", i_ref_setup, 923);
        tick(3);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("t5_abort_busy", busy, 0);
        check("t5_abort_iref", i_ref_setup, 923);
        tick(20);
        check("t5_idle_busy", busy, 0);
        check("t5_idle_iref", i_ref_setup, 923);
        start = 1'b1; abort = 1'b1;
        tick(1);
        start = 1'b0; abort = 1'b0;
        tick(2);
        check("t5_sa_busy", busy, 0);
        check("t5_sa_iref", i_ref_setup, 923);
        check("t5_sa_qpeak", q_peak, 10);
        // Start while busy is ignored.
        do_start();
        feed(50);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(15);
        q_valid = 1'b1; q_measured = 20;
        tick(1);
        q_valid = 1'b0;
        check("t5_busy_start_iref", i_ref_setup, 923);
        check("t5_busy_start_qpeak", q_peak, 50);
        check("t5_busy_start_busy", busy, 1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;

        // Threshold boundary: +300 is stable, +301 is unstable; first fine sample has no predecessor.
        do_start();
        feed(0);
        feed(300);
        check("bnd_eq_stable", i_ref_setup, 923);
        feed(601);
        check("bnd_gt_backoff", i_ref_setup, 973);
        feed(1023);
        check("bnd_fine_first", i_ref_setup, 968);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;

        // 6. Negative jump of 400 is not instability; async reset mid-WAIT_Q.
        do_start();
        feed(450);
        feed(50);
        check("t6_neg_iref", i_ref_setup, 923);
        check("t6_neg_busy", busy, 1);
        feed(60);
        check("t6_coarse_step", i_ref_setup, 873);
        check("t6_qpeak", q_peak, 450);
        check("t6_atpeak", i_ref_at_peak, 1023);
        tick(18);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_iref", i_ref_setup, 1023);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_qpeak", q_peak, 0);
        check("t6_rst_atpeak", i_ref_at_peak, 1023);
        check("t6_rst_locked", locked, 0);
        check("t6_rst_fail", fail, 0);
        tick(1);
        rst = 1'b0;
        tick(20);
        check("t6_post_busy", busy, 0);
        check("t6_post_iref", i_ref_setup, 1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
